// File: rtl/submit_conditioner.sv
// Conditions the raw submit button and guess switches for the game logic:
// two-flop synchronisers, a debounce FSM for the button and a stability filter for the switches.
module submit_conditioner #(
  parameter int SW_WIDTH        = 12,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 200000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                btn_submit,
  input  logic [SW_WIDTH-1:0] sw,
  output logic                submit_pulse,
  output logic [SW_WIDTH-1:0] guess,
  output logic                sw_stable,
  output logic                btn_level,
  output logic                long_press_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  logic                btn_meta, btn_s;
  logic [SW_WIDTH-1:0] sw_meta, sw_s;

  btn_state_e    state, state_next;
  logic [DW-1:0] db_cnt, db_cnt_next;
  logic [HW-1:0] hold_cnt;
  logic          enter_pressed, press_entered;

  logic [SW_WIDTH-1:0] sw_prev;
  logic [DW-1:0]       sw_cnt;
  logic                sw_changed, sw_load, load_pending;

  // Both inputs are asynchronous to clk; the second flop resolves metastability.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      btn_meta <= btn_submit;
      btn_s    <= btn_meta;
      sw_meta  <= sw;
      sw_s     <= sw_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state  <= state_next;
      db_cnt <= db_cnt_next;
    end
  end

  // NOTE: defaults at the top of every combinational block keep it free of inferred latches.
  always_comb begin
    state_next  = state;
    db_cnt_next = db_cnt;
    unique case (state)
      IDLE: begin
        db_cnt_next = '0;
        if (btn_s) begin
          state_next  = PRESS_WAIT;
          db_cnt_next = DW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next  = PRESSED;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt + DW'(1);
        end
      end
      PRESSED: begin
        db_cnt_next = '0;
        if (!btn_s) begin
          state_next  = RELEASE_WAIT;
          db_cnt_next = DW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next  = PRESSED;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt + DW'(1);
        end
      end
      default: begin
        state_next  = IDLE;
        db_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    btn_level     = (state == PRESSED) || (state == RELEASE_WAIT);
    enter_pressed = (state == PRESS_WAIT) && (state_next == PRESSED);
  end

  // The hold count survives release bounces and only clears once the button is back in IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_cnt         <= '0;
      long_press_pulse <= 1'b0;
      press_entered    <= 1'b0;
      submit_pulse     <= 1'b0;
    end else begin
      if (state_next == IDLE) begin
        hold_cnt <= '0;
      end else if (state == PRESSED && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
      long_press_pulse <= (state == PRESSED) && (hold_cnt == HOLD_LAST);
      press_entered    <= enter_pressed;
      submit_pulse     <= press_entered;
    end
  end

  assign sw_changed = (sw_s != sw_prev);
  assign sw_load    = !sw_changed && (sw_cnt == DB_LAST);
  assign sw_stable  = (sw_cnt == DB_MAX);

  // A load colliding with the submit pulse is replayed next cycle from sw_prev, which still holds it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_prev      <= '0;
      sw_cnt       <= '0;
      guess        <= '0;
      load_pending <= 1'b0;
    end else begin
      sw_prev <= sw_s;
      if (sw_changed) begin
        sw_cnt <= '0;
      end else if (sw_cnt != DB_MAX) begin
        sw_cnt <= sw_cnt + DW'(1);
      end
      load_pending <= sw_load && press_entered;
      if (load_pending) begin
        guess <= sw_prev;
      end else if (sw_load && !press_entered) begin
        guess <= sw_s;
      end
    end
  end

endmodule

// File: tb/tb_submit_conditioner.sv
// Directed and randomised stimulus for submit_conditioner, checked every cycle against a
// run-length reference model plus explicit timing checks for the documented scenarios.
module tb_submit_conditioner;

  localparam int SW_W = 12;
  localparam int DB   = 4;
  localparam int HOLD = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            btn_submit;
  logic [SW_W-1:0] sw;
  logic            submit_pulse;
  logic [SW_W-1:0] guess;
  logic            sw_stable;
  logic            btn_level;
  logic            long_press_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  int   edge_no         = 0;
  int   n_sub           = 0;
  int   n_long          = 0;
  int   last_sub_edge   = -1;
  int   last_long_edge  = -1;
  int   level_rise_edge = -1;
  logic prev_level_obs  = 1'b0;

  // Reference model: synchroniser pipelines plus run-length view of the sampled inputs.
  bit            m_b1, m_b2;
  logic [SW_W-1:0] m_sw1, m_sw2;
  bit            m_level, m_prev_samp, m_rose;
  int            m_run, m_hold, m_age;
  bit            m_submit, m_long, m_stable, m_pend;
  logic [SW_W-1:0] m_guess, m_sw_prev, m_pend_val;

  submit_conditioner #(
    .SW_WIDTH        (SW_W),
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .btn_submit       (btn_submit),
    .sw               (sw),
    .submit_pulse     (submit_pulse),
    .guess            (guess),
    .sw_stable        (sw_stable),
    .btn_level        (btn_level),
    .long_press_pulse (long_press_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_b1 = 0; m_b2 = 0; m_sw1 = '0; m_sw2 = '0;
    m_level = 0; m_prev_samp = 0; m_rose = 0;
    m_run = 0; m_hold = 0; m_age = 0;
    m_submit = 0; m_long = 0; m_stable = 0; m_pend = 0;
    m_guess = '0; m_sw_prev = '0; m_pend_val = '0;
  endtask

  // Level flips once the sampled button has disagreed with it for DB consecutive samples;
  // the hold time counts samples spent debounced-high and currently seen high.
  task automatic model_edge(input bit b, input logic [SW_W-1:0] s, input bit r);
    bit samp, was_pressed, new_level;
    logic [SW_W-1:0] ssamp;
    if (!r) begin
      model_reset();
      return;
    end
    samp        = m_b2;
    was_pressed = m_level && m_prev_samp;
    m_run       = (samp == m_prev_samp) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
    m_prev_samp = samp;
    new_level   = m_level;
    if (samp != m_level && m_run >= DB) new_level = samp;
    m_submit = m_rose;
    m_rose   = !m_level && new_level;
    m_long   = 0;
    if (was_pressed && m_hold < HOLD) begin
      m_hold = m_hold + 1;
      m_long = (m_hold == HOLD);
    end
    m_level = new_level;
    if (!m_level) m_hold = 0;

    ssamp = m_sw2;
    if (ssamp != m_sw_prev) m_age = 0;
    else if (m_age < 1000) m_age = m_age + 1;
    m_sw_prev = ssamp;
    m_stable  = (m_age >= DB);
    if (m_pend) begin
      m_guess = m_pend_val;
      m_pend  = 0;
    end
    if (m_age == DB) begin
      if (m_submit) begin
        m_pend     = 1;
        m_pend_val = ssamp;
      end else begin
        m_guess = ssamp;
      end
    end

    m_b2 = m_b1; m_b1 = b;
    m_sw2 = m_sw1; m_sw1 = s;
  endtask

  task automatic cycle(input bit b, input logic [SW_W-1:0] s, input bit r);
    btn_submit = b;
    sw         = s;
    reset_n    = r;
    @(posedge clk);
    edge_no++;
    model_edge(b, s, r);
    @(negedge clk);
    if (submit_pulse === 1'b1) begin n_sub++; last_sub_edge = edge_no; end
    if (long_press_pulse === 1'b1) begin n_long++; last_long_edge = edge_no; end
    if (btn_level === 1'b1 && prev_level_obs !== 1'b1) level_rise_edge = edge_no;
    prev_level_obs = btn_level;
    check("model_submit_pulse", 32'(submit_pulse), 32'(m_submit));
    check("model_long_press", 32'(long_press_pulse), 32'(m_long));
    check("model_btn_level", 32'(btn_level), 32'(m_level));
    check("model_sw_stable", 32'(sw_stable), 32'(m_stable));
    check("model_guess", 32'(guess), 32'(m_guess));
  endtask

  initial begin
    int base_sub, base_long, rise, hold_start, rel, left, len;
    bit lvl;
    logic [SW_W-1:0] v1, v2;
    bit rb;
    int btn_left, sw_left;
    bit btn_val;
    logic [SW_W-1:0] sw_val;

    model_reset();
    reset_n    = 1'b0;
    btn_submit = 1'b0;
    sw         = '0;

    // Reset with random raw inputs: everything must read zero.
    repeat (3) cycle(1'($urandom_range(0, 1)), SW_W'($urandom), 1'b0);
    check("reset_submit", 32'(submit_pulse), 0);
    check("reset_long", 32'(long_press_pulse), 0);
    check("reset_level", 32'(btn_level), 0);
    check("reset_stable", 32'(sw_stable), 0);
    check("reset_guess", 32'(guess), 0);
    repeat (10) cycle(1'b0, '0, 1'b1);

    // Clean press.
    base_sub = n_sub;
    rise     = edge_no + 1;
    repeat (12) cycle(1'b1, '0, 1'b1);
    check("clean_pulse_count", n_sub - base_sub, 1);
    check("clean_pulse_latency", last_sub_edge - rise, DB + 2);
    check("clean_level_latency", level_rise_edge - rise, DB + 1);
    repeat (12) cycle(1'b0, '0, 1'b1);

    // Bouncing press: segments of 1-3 cycles, then a steady hold.
    base_sub = n_sub;
    lvl      = 1'b1;
    left     = 20;
    while (left > 0) begin
      len = $urandom_range(1, 3);
      if (len > left) len = left;
      repeat (len) cycle(lvl, '0, 1'b1);
      left -= len;
      lvl   = !lvl;
    end
    cycle(1'b0, '0, 1'b1);
    check("bounce_no_early_pulse", n_sub - base_sub, 0);
    rise = edge_no + 1;
    repeat (12) cycle(1'b1, '0, 1'b1);
    check("bounce_pulse_count", n_sub - base_sub, 1);
    check("bounce_pulse_latency", last_sub_edge - rise, DB + 2);
    repeat (12) cycle(1'b0, '0, 1'b1);

    // Switches: settle on 0x123, then 0x7FF with a 3-cycle bounce.
    repeat (12) cycle(1'b0, 12'h123, 1'b1);
    check("sw_settled_guess", 32'(guess), 32'h123);
    v1 = SW_W'($urandom);
    if (v1 == 12'h7FF) v1 = 12'h000;
    v2 = SW_W'($urandom);
    if (v2 == 12'h7FF) v2 = 12'h555;
    cycle(1'b0, 12'h7FF, 1'b1);
    check("sw_bounce_guess_0", 32'(guess), 32'h123);
    cycle(1'b0, v1, 1'b1);
    check("sw_bounce_guess_1", 32'(guess), 32'h123);
    cycle(1'b0, 12'h7FF, 1'b1);
    check("sw_bounce_guess_2", 32'(guess), 32'h123);
    check("sw_bounce_stable_2", 32'(sw_stable), 0);
    cycle(1'b0, v2, 1'b1);
    check("sw_bounce_guess_3", 32'(guess), 32'h123);
    check("sw_bounce_stable_3", 32'(sw_stable), 0);
    hold_start = edge_no + 1;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 12'h7FF, 1'b1);
      rel = edge_no - hold_start;
      if (rel == 5) begin
        check("sw_before_latency_guess", 32'(guess), 32'h123);
        check("sw_before_latency_stable", 32'(sw_stable), 0);
      end
      if (rel == 6) begin
        check("sw_at_latency_guess", 32'(guess), 32'h7FF);
        check("sw_at_latency_stable", 32'(sw_stable), 1);
      end
    end

    // Long press.
    base_sub  = n_sub;
    base_long = n_long;
    repeat (40) cycle(1'b1, 12'h7FF, 1'b1);
    check("long_submit_count", n_sub - base_sub, 1);
    check("long_pulse_count", n_long - base_long, 1);
    check("long_pulse_latency", last_long_edge - level_rise_edge, HOLD);
    repeat (12) cycle(1'b0, 12'h7FF, 1'b1);
    check("long_no_second_pulse", n_long - base_long, 1);

    // Release bounce while pressed.
    repeat (12) cycle(1'b1, 12'h7FF, 1'b1);
    base_sub = n_sub;
    for (int k = 0; k < 10; k++) begin
      cycle((k >= 2), 12'h7FF, 1'b1);
      check("release_bounce_level", 32'(btn_level), 1);
    end
    check("release_bounce_no_pulse", n_sub - base_sub, 0);
    repeat (12) cycle(1'b0, 12'h7FF, 1'b1);

    // Reset while the press counter sits at 3.
    base_sub = n_sub;
    repeat (5) cycle(1'b1, 12'h7FF, 1'b1);
    repeat (2) cycle(1'b1, 12'h7FF, 1'b0);
    check("midreset_submit", 32'(submit_pulse), 0);
    check("midreset_level", 32'(btn_level), 0);
    check("midreset_guess", 32'(guess), 0);
    check("midreset_stable", 32'(sw_stable), 0);
    repeat (8) cycle(1'b0, 12'h7FF, 1'b1);
    check("midreset_no_pulse", n_sub - base_sub, 0);
    rise = edge_no + 1;
    repeat (12) cycle(1'b1, 12'h7FF, 1'b1);
    check("midreset_new_pulse_count", n_sub - base_sub, 1);
    check("midreset_new_pulse_latency", last_sub_edge - rise, DB + 2);
    repeat (12) cycle(1'b0, 12'h7FF, 1'b1);

    // Guess load coinciding with the submit pulse is pushed back one cycle.
    rise = edge_no + 1;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 12'h3C3, 1'b1);
      rel = edge_no - rise;
      if (rel == 6) begin
        check("defer_submit", 32'(submit_pulse), 1);
        check("defer_guess_held", 32'(guess), 32'h7FF);
      end
      if (rel == 7) check("defer_guess_loaded", 32'(guess), 32'h3C3);
    end
    repeat (12) cycle(1'b0, 12'h3C3, 1'b1);

    // Random runs on both inputs with occasional resets.
    btn_left = 0;
    sw_left  = 0;
    btn_val  = 1'b0;
    sw_val   = '0;
    for (int k = 0; k < 1500; k++) begin
      if (btn_left == 0) begin
        btn_val  = 1'($urandom_range(0, 1));
        btn_left = $urandom_range(1, 30);
      end
      if (sw_left == 0) begin
        sw_val  = SW_W'($urandom);
        sw_left = $urandom_range(1, 12);
      end
      rb = ($urandom_range(0, 199) != 0);
      cycle(btn_val, sw_val, rb);
      btn_left--;
      sw_left--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/submit_conditioner.md
# submit_conditioner

Input-conditioning stage placed directly upstream of the guessing-game top level. It synchronises and debounces the raw submit push-button and the 12 guess switches, then delivers a single-cycle `submit_pulse` together with a stable, registered `guess` value, so the game logic compares a clean snapshot instead of raw bouncing inputs. It also reports the debounced button level and a long-press pulse, which the game uses as a "new game" request.

## Interface
Parameters:
- `SW_WIDTH`, 12: width of the switch bus and `guess`.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable samples required; 10 ms at 100 MHz; must be at least 2.
- `HOLD_CYCLES`, 200000000: cycles the button must stay in PRESSED before `long_press_pulse` fires; 2 s at 100 MHz; must be greater than `DEBOUNCE_CYCLES`.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `btn_submit`  in  1  raw, asynchronous push-button.
- `sw`  in  SW_WIDTH  raw, asynchronous switches.
- `submit_pulse`  out  1  one-cycle pulse for each debounced press.
- `guess`  out  SW_WIDTH  debounced switch value, registered.
- `sw_stable`  out  1  high while the synchronised `sw` has been unchanged for at least `DEBOUNCE_CYCLES` cycles.
- `btn_level`  out  1  debounced button level.
- `long_press_pulse`  out  1  one-cycle pulse when a press is held `HOLD_CYCLES` cycles.

## Operation
- Input sync: two-flop synchroniser on `btn_submit` and on each `sw` bit, giving `btn_s` and `sw_s`.
- Button FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. The debounce counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
  - IDLE: if `btn_s=1`, go to PRESS_WAIT with the counter at 1.
  - PRESS_WAIT: if `btn_s=1`, increment the counter; when the counter reaches `DEBOUNCE_CYCLES`, go to PRESSED. If `btn_s=0`, go to IDLE and clear the counter.
  - PRESSED: `btn_level=1`. The hold counter increments each cycle, saturating at `HOLD_CYCLES`. If `btn_s=0`, go to RELEASE_WAIT with the counter at 1.
  - RELEASE_WAIT: if `btn_s=0`, increment the counter; when it reaches `DEBOUNCE_CYCLES`, go to IDLE and set `btn_level=0`. If `btn_s=1`, return to PRESSED; the hold counter keeps its value.
- `submit_pulse` is registered. It is 1 exactly in the cycle after the PRESS_WAIT→PRESSED transition.
- `long_press_pulse` is registered. It is 1 for one cycle when the hold counter first equals `HOLD_CYCLES`, and at most once per press. The hold counter clears on entry to IDLE.
- Switch filter:
  - A stability counter tracks `sw_s`. If `sw_s` differs from its previous-cycle value, the counter clears to 0.
  - Otherwise the counter increments, saturating at `DEBOUNCE_CYCLES`.
  - `sw_stable` is 1 while the counter is at `DEBOUNCE_CYCLES`.
  - `guess` loads `sw_s` on the cycle the counter reaches `DEBOUNCE_CYCLES`. It holds its value while the switches bounce.
- `guess` never changes in the same cycle that `submit_pulse=1`. If a new stable value arrives that cycle, the load is deferred by one cycle.

## Timing
- Reset (`reset_n=0` at a clock edge): all outputs are 0, the FSM is in IDLE, all counters and synchroniser flops are 0. `guess` resets to 0.
- Reset asserted mid-press or mid-count aborts the operation with no pulse. After release, the button must be seen low (IDLE) and then a full press must be detected before the next `submit_pulse`.
- Press latency: raw rise at cycle r gives `btn_s=1` at r+2 and `submit_pulse` at r+2+`DEBOUNCE_CYCLES`.
- Release latency: `btn_level` falls `DEBOUNCE_CYCLES` cycles after `btn_s` falls.
- Long press: `long_press_pulse` fires `HOLD_CYCLES` cycles after entry to PRESSED.
- Switch latency: `guess` and `sw_stable` update at raw change + 2 + `DEBOUNCE_CYCLES`.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles on either input produce no output change.
- Repeated pulses require a full release (back to IDLE) between presses.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=16`, `SW_WIDTH=12`.
- Clean press: `btn_submit` rises at cycle 10 and stays high → exactly one `submit_pulse`, at cycle 16; `btn_level=1` from cycle 15.
- Bounce: button toggles with 1–3 cycle periods for 20 cycles, then holds high → one pulse, 6 cycles after the final rise; no earlier pulse.
- Switches: `sw` set to 0x7FF, bounced for 3 cycles, then held → `guess=0x7FF` and `sw_stable=1` at hold start + 6. During the bounce, `guess` keeps its old value and `sw_stable=0`.
- Long press: hold the button for 40 cycles → one `submit_pulse` and one `long_press_pulse`, the latter 16 cycles after entry to PRESSED; no second long-press pulse.
- Release-bounce: in PRESSED, drop the button for 2 cycles then restore it → stays in PRESSED, no new `submit_pulse`, `btn_level` stays 1.
- Reset mid-count: `reset_n=0` while in PRESS_WAIT with the counter at 3 → no pulse and all outputs 0. A new clean press afterwards → one pulse with the full latency.
